// File: rtl/bfloat16_pkg.sv
// bfloat16_pkg: shared widths, raw-mantissa bit positions, state encoding and
// IEEE-style constants for the bfloat16 adder back end.
package bfloat16_pkg;

  localparam int MANT_W = 11;  // {carry, hidden, frac[6:0], guard, sticky}
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;

  // Bit positions inside the raw mantissa
  localparam int CARRY_BIT  = 10;
  localparam int HIDDEN_BIT = 9;
  localparam int FRAC_HI    = 8;
  localparam int FRAC_LO    = 2;
  localparam int GUARD_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0]      POS_INF = 16'h7F80;
  localparam logic [15:0]      NEG_INF = 16'hFF80;
  localparam logic [15:0]      QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int               BIAS    = 127;

endpackage

// File: rtl/bfloat16_normalizer_if.sv
// bfloat16_normalizer_if: raw-sum input channel and packed-result output
// channel of the normalizer, each with a valid/ready handshake.
//   slave  : the normalizer's view (consumes in_*, produces out_*)
//   master : the environment's view (adder upstream + result consumer)
interface bfloat16_normalizer_if;
  import bfloat16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exponent;
  logic [MANT_W-1:0] in_mantissa;
  logic              in_special;
  logic [15:0]       in_special_value;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_special,
           in_special_value, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact
  );

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_special,
           in_special_value, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_inexact
  );
endinterface

// File: rtl/bfloat16_round.sv
// bfloat16_round: combinational round-to-nearest-even and packing.
// Inputs : sign_i, exp_i (9-bit, never wraps), hidden_i, frac_i, guard_i,
//          sticky_i, subnormal_i (exponent bottomed out with hidden clear)
// Outputs: result_o (packed bfloat16), overflow_o, inexact_o, underflow_o
module bfloat16_round
  import bfloat16_pkg::*;
(
  input  logic              sign_i,
  input  logic [EXP_W:0]    exp_i,
  input  logic              hidden_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic              subnormal_i,
  output logic [15:0]       result_o,
  output logic              overflow_o,
  output logic              inexact_o,
  output logic              underflow_o
);

  logic            denorm;
  logic            round_up;
  logic            inexact_raw;
  logic [FRAC_W:0] frac_inc;  // MSB is the carry out of the fraction
  logic [EXP_W:0]  exp_rnd;

  assign denorm      = subnormal_i | ~hidden_i;
  assign inexact_raw = guard_i | sticky_i;
  assign round_up    = guard_i & (sticky_i | frac_i[0]);
  assign frac_inc    = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};

  // NOTE: every output gets a value before any branch so no latch is inferred.
  always_comb begin
    result_o    = '0;
    overflow_o  = 1'b0;
    inexact_o   = inexact_raw;
    underflow_o = 1'b0;
    // A subnormal that rounds past 0x7F gains the hidden bit: stored exp 1.
    if (denorm) exp_rnd = frac_inc[FRAC_W] ? 9'd1 : 9'd0;
    else        exp_rnd = exp_i + {{EXP_W{1'b0}}, frac_inc[FRAC_W]};

    if (!denorm && exp_rnd >= {1'b0, EXP_MAX}) begin
      result_o   = sign_i ? NEG_INF : POS_INF;
      overflow_o = 1'b1;
      inexact_o  = 1'b1;
    end else begin
      result_o    = {sign_i, exp_rnd[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
      underflow_o = denorm & inexact_raw;
    end
  end

endmodule

// File: rtl/bfloat16_normalizer.sv
// bfloat16_normalizer: turns the adder's raw sum into a packed bfloat16.
// Ports: clock, n_reset (async, active low), bus (slave modport):
//   in_*  raw sum {sign, exponent, carry/hidden/frac/guard/sticky mantissa}
//         or an already-resolved special value, valid/ready handshake
//   out_* packed result plus overflow/underflow/inexact, valid/ready
// One right shift or up to nine left shifts (one per cycle), then one
// rounding cycle; the result is held in DONE until the consumer takes it.
module bfloat16_normalizer
  import bfloat16_pkg::*;
(
  input  logic                  clock,
  input  logic                  n_reset,
  bfloat16_normalizer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_NORM  = NORM;
  localparam logic [1:0] S_ROUND = ROUND;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]        state_q,  state_d;
  logic              sign_q,   sign_d;
  logic [EXP_W:0]    exp_q,    exp_d;    // 9 bits: 255/256 visible without wrap
  logic              hid_q,    hid_d;
  logic [FRAC_W-1:0] frac_q,   frac_d;
  logic              guard_q,  guard_d;
  logic              sticky_q, sticky_d;
  logic              sub_q,    sub_d;
  logic [15:0]       result_q, result_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;
  logic              inx_q,    inx_d;

  logic [EXP_W:0]    exp_in;
  logic [15:0]       rnd_result;
  logic              rnd_ovf, rnd_inx, rnd_unf;

  // A zero exponent on a non-special sum behaves like exponent 1.
  assign exp_in = (bus.in_exponent == '0) ? 9'd1 : {1'b0, bus.in_exponent};

  bfloat16_round u_round (
    .sign_i      (sign_q),
    .exp_i       (exp_q),
    .hidden_i    (hid_q),
    .frac_i      (frac_q),
    .guard_i     (guard_q),
    .sticky_i    (sticky_q),
    .subnormal_i (sub_q),
    .result_o    (rnd_result),
    .overflow_o  (rnd_ovf),
    .inexact_o   (rnd_inx),
    .underflow_o (rnd_unf)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    hid_d    = hid_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    sub_d    = sub_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          sub_d  = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = 1'b0;
          if (bus.in_special) begin
            result_d = bus.in_special_value;
            state_d  = S_DONE;
          end else if (bus.in_mantissa == '0) begin
            result_d = 16'h0000;  // exact cancellation gives +0
            state_d  = S_DONE;
          end else if (bus.in_mantissa[CARRY_BIT]) begin
            hid_d    = 1'b1;
            frac_d   = bus.in_mantissa[HIDDEN_BIT:FRAC_LO+1];
            guard_d  = bus.in_mantissa[FRAC_LO];
            sticky_d = bus.in_mantissa[GUARD_BIT] | bus.in_mantissa[STICKY_BIT];
            exp_d    = exp_in + 9'd1;
            state_d  = S_ROUND;
          end else begin
            hid_d    = bus.in_mantissa[HIDDEN_BIT];
            frac_d   = bus.in_mantissa[FRAC_HI:FRAC_LO];
            guard_d  = bus.in_mantissa[GUARD_BIT];
            sticky_d = bus.in_mantissa[STICKY_BIT];
            exp_d    = exp_in;
            state_d  = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (hid_q) begin
          state_d = S_ROUND;
        end else if (exp_q == 9'd1) begin
          sub_d   = 1'b1;
          state_d = S_ROUND;
        end else begin
          {hid_d, frac_d, guard_d} = {frac_q, guard_q, sticky_q};
          sticky_d = 1'b0;
          exp_d    = exp_q - 9'd1;
        end
      end
      S_ROUND: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        unf_d    = rnd_unf;
        inx_d    = rnd_inx;
        state_d  = S_DONE;
      end
      default: begin  // S_DONE
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: datapath registers are reset too, so out_result reads 0 after any
  // reset instead of a stale value; this is a flop bank, not a memory.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      hid_q    <= 1'b0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      hid_q    <= hid_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  // Handshake outputs are pure state decodes: no input-to-output path.
  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.out_valid     = (state_q == S_DONE);
  assign bus.out_result    = result_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
  assign bus.out_inexact   = inx_q;

endmodule

// File: tb/tb_bfloat16_normalizer.sv
// tb_bfloat16_normalizer: directed and randomized checks of the normalizer
// against an arithmetic reference model of normalize/round/pack.
module tb_bfloat16_normalizer;
  import bfloat16_pkg::*;

  logic clock;
  logic n_reset;
  int   checks;
  int   errors;

  bfloat16_normalizer_if bus ();

  bfloat16_normalizer dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: treat the raw mantissa as an integer M with the hidden bit at
  // weight 2^0 (bit 9), pick the target exponent, rescale, then round.
  function automatic void model(input logic s, input logic [7:0] e,
                                input logic [10:0] m, input logic sp,
                                input logic [15:0] spv,
                                output logic [15:0] res, output logic [2:0] flg,
                                output int lat);
    int     ex, p, ne, sig, stored;
    longint sc, sh;
    logic   g, st, sub, inx;
    ex  = (e == 0) ? 1 : int'(e);
    flg = 3'b000;
    lat = 1;
    res = 16'h0000;
    if (sp) begin
      res = spv;
      return;
    end
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 11; i++) if (m[i]) p = i;
    sc = longint'(m) << 8;  // hidden now at bit 17, 8 spare bits below
    if (p == 10) begin
      ne  = ex + 1;
      sh  = sc >> 1;
      lat = 2;
    end else begin
      ne = ex - (9 - p);
      if (ne < 1) ne = 1;
      sh  = sc << (ex - ne);
      lat = 3 + (ex - ne);
    end
    sig = int'((sh >> 10) & 255);
    g   = ((sh >> 9) & 1) != 0;
    st  = (sh & 511) != 0;
    sub = (sig < 128);
    inx = g | st;
    if (g && (st || (sig % 2 == 1))) sig = sig + 1;
    if (sig == 256) begin
      sig = 128;
      ne  = ne + 1;
    end
    if (sig >= 128 && ne >= 255) begin
      res = {s, 8'hFF, 7'h00};
      flg = 3'b101;  // {overflow, underflow, inexact}
    end else begin
      stored = (sig >= 128) ? ne : 0;
      res = {s, stored[7:0], sig[6:0]};
      flg = {1'b0, sub & inx, inx};
    end
  endfunction

  task automatic drive_in(input logic s, input logic [7:0] e,
                          input logic [10:0] m, input logic sp,
                          input logic [15:0] spv);
    bus.in_valid         = 1'b1;
    bus.in_sign          = s;
    bus.in_exponent      = e;
    bus.in_mantissa      = m;
    bus.in_special       = sp;
    bus.in_special_value = spv;
  endtask

  // Waits (bounded) for out_valid; n = edges waited after the accept edge.
  task automatic wait_valid(input string name, output int n, output logic ok);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    ok = bus.out_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: out_valid never rose", name);
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] exp_res,
                              input logic [2:0] exp_flg);
    logic [2:0] flg;
    flg = {bus.out_overflow, bus.out_underflow, bus.out_inexact};
    checks++;
    if (bus.out_result !== exp_res || flg !== exp_flg) begin
      errors++;
      $display("FAIL %s result: got %h flags %b want %h flags %b",
               name, bus.out_result, flg, exp_res, exp_flg);
    end
  endtask

  task automatic handoff(input string name);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handoff: out_valid %b in_ready %b want 0 1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [7:0] e,
                        input logic [10:0] m, input logic sp,
                        input logic [15:0] spv, input int hold);
    logic [15:0] exp_res;
    logic [2:0]  exp_flg;
    int          exp_lat, n;
    logic        ok;
    model(s, e, m, sp, spv, exp_res, exp_flg, exp_lat);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    drive_in(s, e, m, sp, spv);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(name, n, ok);
    if (!ok) return;
    checks++;
    if (n + 1 != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n + 1, exp_lat);
    end
    check_result(name, exp_res, exp_flg);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_result !== exp_res) begin
        errors++;
        $display("FAIL %s hold: valid %b ready %b result %h want 1 0 %h",
                 name, bus.out_valid, bus.in_ready, bus.out_result, exp_res);
      end
    end
    handoff(name);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_result !== 16'h0000 || bus.out_overflow !== 1'b0 ||
        bus.out_underflow !== 1'b0 || bus.out_inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset state: ready %b valid %b result %h flags %b%b%b",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_overflow,
               bus.out_underflow, bus.out_inexact);
    end
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_directed();
    run_op("one_plus_one", 1'b0, 8'(BIAS), 11'b100_0000_0000, 1'b0, 16'h0, 0);
    run_op("cancel",       1'b0, 8'd130, 11'b000_0010_0000, 1'b0, 16'h0, 0);
    run_op("tie_odd",      1'b0, 8'(BIAS), {1'b0, 1'b1, 7'b0000001, 1'b1, 1'b0}, 1'b0, 16'h0, 0);
    run_op("tie_even",     1'b0, 8'(BIAS), {1'b0, 1'b1, 7'b0000000, 1'b1, 1'b0}, 1'b0, 16'h0, 0);
    run_op("overflow",     1'b0, 8'd254, 11'b100_0000_0000, 1'b0, 16'h0, 0);
    run_op("neg_overflow", 1'b1, 8'd255, 11'b010_0000_0000, 1'b0, 16'h0, 0);
    run_op("special",      1'b0, 8'd3,   11'h155, 1'b1, 16'h7FC1, 0);
    run_op("qnan",         1'b1, 8'd0,   11'h0,   1'b1, QNAN, 0);
    run_op("subnormal",    1'b0, 8'd3,   11'b000_0000_0111, 1'b0, 16'h0, 0);
    run_op("sub_round_up", 1'b0, 8'd1,   11'b011_1111_1110, 1'b0, 16'h0, 0);
    run_op("exp_zero_in",  1'b1, 8'd0,   11'b001_0101_0101, 1'b0, 16'h0, 0);
    run_op("nine_shifts",  1'b0, 8'd20,  11'b000_0000_0001, 1'b0, 16'h0, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 1'b1, 8'd140, 11'b011_0110_0111, 1'b0, 16'h0, 5);
    run_op("zero",         1'b1, 8'd140, 11'h000, 1'b0, 16'h0, 2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    logic [2:0]  fa, fb;
    int          la, lb, n;
    logic        ok;
    model(1'b0, 8'd100, 11'b000_1000_0011, 1'b0, 16'h0, ra, fa, la);
    model(1'b1, 8'd60,  11'b110_0000_0011, 1'b0, 16'h0, rb, fb, lb);
    @(negedge clock);
    drive_in(1'b0, 8'd100, 11'b000_1000_0011, 1'b0, 16'h0);
    @(posedge clock);
    #1;
    // Next operand appears immediately and stays valid while the block is busy.
    drive_in(1'b1, 8'd60, 11'b110_0000_0011, 1'b0, 16'h0);
    wait_valid("b2b_first", n, ok);
    if (!ok) return;
    check_result("b2b_first", ra, fa);
    handoff("b2b_first");
    @(posedge clock);  // operand B accepted here
    #1;
    bus.in_valid = 1'b0;
    wait_valid("b2b_second", n, ok);
    if (!ok) return;
    checks++;
    if (n + 1 != lb) begin
      errors++;
      $display("FAIL b2b_second latency: got %0d want %0d", n + 1, lb);
    end
    check_result("b2b_second", rb, fb);
    handoff("b2b_second");
  endtask

  task automatic test_reset_mid_norm();
    @(negedge clock);
    drive_in(1'b0, 8'd130, 11'b000_0000_0100, 1'b0, 16'h0);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_norm: valid %b ready %b result %h want 0 1 0000",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
    @(negedge clock);
    n_reset = 1'b1;
    run_op("after_reset", 1'b0, 8'd130, 11'b000_0010_0000, 1'b0, 16'h0, 0);
    // Reset while a result is waiting must drop out_valid at once.
    @(negedge clock);
    drive_in(1'b0, 8'(BIAS), 11'b100_0000_0000, 1'b0, 16'h0);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_in_done: valid %b result %h want 0 0000",
               bus.out_valid, bus.out_result);
    end
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_random();
    logic        s, sp;
    logic [7:0]  e;
    logic [10:0] m;
    logic [15:0] spv;
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       e = 8'd0;
        1:       e = 8'd1;
        2:       e = 8'd254;
        3:       e = 8'd255;
        default: e = 8'($urandom);
      endcase
      m   = 11'($urandom) >> $urandom_range(0, 10);
      sp  = ($urandom_range(0, 11) == 0);
      spv = 16'($urandom);
      run_op($sformatf("rand%0d", i), s, e, m, sp, spv, $urandom_range(0, 2));
    end
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    n_reset              = 1'b0;
    bus.in_valid         = 1'b0;
    bus.in_sign          = 1'b0;
    bus.in_exponent      = '0;
    bus.in_mantissa      = '0;
    bus.in_special       = 1'b0;
    bus.in_special_value = '0;
    bus.out_ready        = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_norm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
